// File: rtl/decap_seq_pkg.sv
// decap_seq_pkg: shared state encoding and default sizing for the decapsulation sequencer
package decap_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, READY, RUN, FIN} state_t;
  localparam int M_DEF = 12;
  localparam int TIMEOUT_DEF = 1000000;
  localparam int CNT_W_DEF = 32;
endpackage

// File: rtl/p_port_mux.sv
// p_port_mux: steers the single P memory port between the host loader and the decryption core
module p_port_mux
  import decap_seq_pkg::*;
#(
  parameter int m = M_DEF
) (
  input  state_t         state,
  input  logic           load_wr_en,
  input  logic [m-1:0]   load_wr_addr,
  input  logic [m-1:0]   load_wr_data,
  input  logic [m-1:0]   P_rd_addr,
  output logic [m-1:0]   mem_addr,
  output logic [m-1:0]   mem_wr_data,
  output logic           mem_wren
);
  always_comb begin
    mem_addr    = state == LOAD ? load_wr_addr : state == RUN ? P_rd_addr : '0;
    mem_wr_data = state == LOAD ? load_wr_data : '0;
    mem_wren    = state == LOAD && load_wr_en;
  end
endmodule

// File: rtl/decap_seq.sv
// decap_seq: load/run sequencer, P port arbiter, run-length counter and watchdog for decryption
module decap_seq
  import decap_seq_pkg::*;
#(
  parameter int m       = M_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             load_wr_en,
  input  logic [m-1:0]     load_wr_addr,
  input  logic [m-1:0]     load_wr_data,
  input  logic             dec_req,
  input  logic             dec_done,
  input  logic             dec_fail,
  input  logic             P_rd_en,
  input  logic [m-1:0]     P_rd_addr,
  output logic             dec_start,
  output logic [m-1:0]     mem_addr,
  output logic [m-1:0]     mem_wr_data,
  output logic             mem_wren,
  output logic             p_valid,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             timeout,
  output logic             wr_conflict,
  output logic [CNT_W-1:0] cycles
);
  localparam logic [m:0]       W_ONE  = 1;
  localparam logic [m:0]       W_LAST = {1'b0, {m{1'b1}}};
  localparam logic [CNT_W-1:0] C_ONE  = 1;
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  state_t           state;
  logic [m:0]       wr_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic             unused_rd;
  assign unused_rd = P_rd_en;
  p_port_mux #(.m(m)) u_mux (
    .state        (state),
    .load_wr_en   (load_wr_en),
    .load_wr_addr (load_wr_addr),
    .load_wr_data (load_wr_data),
    .P_rd_addr    (P_rd_addr),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wren     (mem_wren)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      run_cnt     <= '0;
      dec_start   <= 1'b0;
      p_valid     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      wr_conflict <= 1'b0;
      cycles      <= '0;
    end else begin
      dec_start <= 1'b0;
      done      <= 1'b0;
      if ((load_wr_en && state != LOAD) || (load_start && (state == RUN || state == FIN)))
        wr_conflict <= 1'b1;
      case (state)
        IDLE, READY: begin
          if (load_start) begin
            state   <= LOAD;
            busy    <= 1'b1;
            p_valid <= 1'b0;
            wr_cnt  <= '0;
          end else if (state == READY && dec_req) begin
            state     <= RUN;
            busy      <= 1'b1;
            dec_start <= 1'b1;
            run_cnt   <= C_ONE;
          end
        end
        LOAD: begin
          if (load_start) wr_cnt <= '0;
          else if (load_wr_en) begin
            wr_cnt <= wr_cnt + W_ONE;
            // the write that completes the table moves straight to READY
            if (wr_cnt == W_LAST) begin
              state   <= READY;
              busy    <= 1'b0;
              p_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (dec_done || run_cnt == TMO) begin
            state   <= FIN;
            busy    <= 1'b0;
            done    <= 1'b1;
            fail    <= dec_done ? dec_fail : 1'b1;
            timeout <= !dec_done;
            cycles  <= run_cnt;
          end else run_cnt <= run_cnt + C_ONE;
        end
        FIN: state <= READY;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_decap_seq.sv
// tb_decap_seq: directed/randomized checks of decap_seq against a spec-level reference model
module tb_decap_seq;
  localparam int M   = 4;
  localparam int TMO = 64;
  logic          clk = 1'b0;
  logic          rst, load_start, load_wr_en, dec_req, dec_done, dec_fail, P_rd_en;
  logic [M-1:0]  load_wr_addr, load_wr_data, P_rd_addr;
  logic          dec_start, mem_wren, p_valid, busy, done, fail, timeout, wr_conflict;
  logic [M-1:0]  mem_addr, mem_wr_data;
  logic [31:0]   cycles;
  int            checks = 0, errors = 0;
  int            wcnt = 0;
  bit            exp_conflict = 0, exp_fail = 0, exp_to = 0;

  decap_seq #(.m(M), .TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_wr_en(load_wr_en),
    .load_wr_addr(load_wr_addr), .load_wr_data(load_wr_data), .dec_req(dec_req),
    .dec_done(dec_done), .dec_fail(dec_fail), .P_rd_en(P_rd_en), .P_rd_addr(P_rd_addr),
    .dec_start(dec_start), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wren(mem_wren),
    .p_valid(p_valid), .busy(busy), .done(done), .fail(fail), .timeout(timeout),
    .wr_conflict(wr_conflict), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dec_start"}, dec_start, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wr_data"}, mem_wr_data, 0);
    chk({tag, "_mem_wren"}, mem_wren, 0);
    chk({tag, "_p_valid"}, p_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_wr_conflict"}, wr_conflict, 0);
    chk({tag, "_cycles"}, cycles, 0);
  endtask

  task automatic enter_load(input bit with_req);
    load_start = 1'b1;
    dec_req = with_req;
    tick();
    load_start = 1'b0;
    dec_req = 1'b0;
    wcnt = 0;
    #1;
    chk("load_entry_busy", busy, 1);
    chk("load_entry_p_valid", p_valid, 0);
    chk("load_entry_dec_start", dec_start, 0);
  endtask

  // host writes with random idle gaps; stray dec_req in the gaps must be ignored
  task automatic load_writes(input int n);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        load_wr_en = 1'b0;
        dec_req = 1'($urandom);
        #1;
        chk("gap_wren", mem_wren, 0);
        chk("gap_busy", busy, 1);
        chk("gap_dec_start", dec_start, 0);
        tick();
      end
      dec_req = 1'b0;
      load_wr_en = 1'b1;
      load_wr_addr = 4'($urandom);
      load_wr_data = 4'($urandom);
      #1;
      chk("wr_addr", mem_addr, load_wr_addr);
      chk("wr_data", mem_wr_data, load_wr_data);
      chk("wr_wren", mem_wren, 1);
      chk("wr_p_valid", p_valid, 0);
      chk("wr_dec_start", dec_start, 0);
      tick();
      wcnt++;
    end
    load_wr_en = 1'b0;
    #1;
    chk("after_wr_p_valid", p_valid, wcnt == (1 << M));
    chk("after_wr_busy", busy, wcnt != (1 << M));
  endtask

  task automatic run(input int delay, input bit f, input bit inject);
    int k;
    bit to_exp;
    dec_req = 1'b1;
    tick();
    dec_req = 1'b0;
    to_exp = delay >= TMO;
    for (k = 0; k < TMO; k++) begin
      P_rd_en = 1'b1;
      P_rd_addr = 4'($urandom);
      dec_done = (k == delay);
      dec_fail = f;
      load_wr_en = inject && k == 2;
      load_wr_addr = 4'($urandom);
      #1;
      chk("run_addr", mem_addr, P_rd_addr);
      chk("run_wren", mem_wren, 0);
      chk("run_busy", busy, 1);
      chk("run_dec_start", dec_start, k == 0);
      chk("run_done", done, 0);
      tick();
      if (k == delay) break;
    end
    if (inject) exp_conflict = 1;
    exp_fail = to_exp ? 1'b1 : f;
    exp_to = to_exp;
    dec_done = 1'b0;
    P_rd_en = 1'b0;
    load_wr_en = 1'b0;
    #1;
    chk("fin_done", done, 1);
    chk("fin_fail", fail, exp_fail);
    chk("fin_timeout", timeout, exp_to);
    chk("fin_busy", busy, 0);
    chk("fin_wr_conflict", wr_conflict, exp_conflict);
    chk("fin_mem_addr", mem_addr, 0);
    if (!to_exp) chk("fin_cycles", cycles, delay + 1);
    dec_done = to_exp;
    tick();
    dec_done = 1'b0;
    #1;
    chk("post_done", done, 0);
    chk("post_fail", fail, exp_fail);
    chk("post_timeout", timeout, exp_to);
    chk("post_p_valid", p_valid, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    {load_start, load_wr_en, dec_req, dec_done, dec_fail, P_rd_en} = '0;
    load_wr_addr = '0;
    load_wr_data = '0;
    P_rd_addr = '0;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    dec_req = 1'b1;
    tick();
    dec_req = 1'b0;
    #1;
    chk("idle_req_dec_start", dec_start, 0);
    chk("idle_req_busy", busy, 0);
    enter_load(1'b0);
    load_writes(5);
    enter_load(1'b0);
    load_writes(15);
    load_writes(1);
    chk("load_no_conflict", wr_conflict, 0);
    run(50, 1'b0, 1'b0);
    run(50, 1'b1, 1'b0);
    run(int'($urandom_range(0, 40)), 1'b0, 1'b0);
    run(TMO - 1, 1'b1, 1'b0);
    run(1000, 1'b0, 1'b0);
    run(int'($urandom_range(5, 60)), 1'($urandom), 1'b1);
    run(0, 1'b0, 1'b0);
    enter_load(1'b1);
    load_writes(16);
    P_rd_addr = 4'hA;
    dec_req = 1'b1;
    tick();
    dec_req = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("mid_run_rst");
    tick();
    rst = 1'b0;
    dec_req = 1'b1;
    tick();
    dec_req = 1'b0;
    #1;
    chk("post_rst_dec_start", dec_start, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_p_valid", p_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
